// File: rtl/mc_pkg.sv
// Shared definitions for the memory controller: FSM states, owners, access size codes
// and the IO-region tag found in address bits [17:16].
package mc_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2
    } mc_state_t;

    typedef enum logic {
        OWN_IC  = 1'b0,
        OWN_LSB = 1'b1
    } mc_owner_t;

    localparam logic [1:0] MC_SIZE_B  = 2'd0;
    localparam logic [1:0] MC_SIZE_H  = 2'd1;
    localparam logic [1:0] MC_SIZE_W  = 2'd2;
    localparam logic [1:0] MC_IO_MASK = 2'b11;

    // Size code 3 is not a legal access; it is served as a full word.
    function automatic logic [2:0] mc_size_bytes(input logic [1:0] size);
        case (size)
            MC_SIZE_B: return 3'd1;
            MC_SIZE_H: return 3'd2;
            default:   return 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/memory_controller.sv
// Arbitrates icache fetches and LSB loads/stores onto a byte-wide RAM/IO bus.
// Optional MC_IO_STALL_EN: hold off IO-region stores while the IO output buffer is full.
module memory_controller
    import mc_pkg::*;
#(
    parameter int         ADDR_WIDTH = 32,
    parameter logic [1:0] IO_MASK    = MC_IO_MASK
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  rdy_in,
    input  logic                  IC_query_en,
    input  logic [ADDR_WIDTH-1:0] IC_query_addr,
    output logic                  IC_data_en,
    output logic [31:0]           IC_data,
    input  logic                  LSB_query_en,
    input  logic                  LSB_query_wr,
    input  logic [ADDR_WIDTH-1:0] LSB_query_addr,
    input  logic [1:0]            LSB_query_size,
    input  logic [31:0]           LSB_query_data,
    output logic                  LSB_done_en,
    output logic [31:0]           LSB_dout,
    input  logic [7:0]            mem_din,
    output logic [7:0]            mem_dout,
    output logic [ADDR_WIDTH-1:0] mem_a,
    output logic                  mem_wr,
    input  logic                  io_buffer_full
);

    mc_state_t             state_reg;
    mc_owner_t             owner_reg;
    logic [ADDR_WIDTH-1:0] addr_reg;
    logic [2:0]            len_reg;
    logic [2:0]            cnt_reg;
    logic [31:0]           wdata_reg;
    logic [31:0]           result_reg;
    logic [31:0]           result_next;
    logic [1:0]            cap_idx;
    logic [1:0]            nxt_idx;
    logic [ADDR_WIDTH-1:0] addr_next;
    logic                  lsb_ok;
    logic                  can_accept;

`ifdef MC_IO_STALL_EN
    always_comb begin
        lsb_ok = LSB_query_en;
        if (LSB_query_wr && (LSB_query_addr[17:16] == IO_MASK) && io_buffer_full)
            lsb_ok = 1'b0;
    end
`else
    logic unused_io;
    assign unused_io = io_buffer_full ^ (^IO_MASK);
    assign lsb_ok    = LSB_query_en;
`endif

    // A done pulse still high means its owner may not have dropped the request yet.
    assign can_accept = !IC_data_en && !LSB_done_en;

    // cnt_reg counts edges spent in READ; the byte landing now belongs to index cnt-1.
    assign cap_idx   = 2'(cnt_reg - 3'd1);
    assign nxt_idx   = 2'(cnt_reg + 3'd1);
    assign addr_next = addr_reg + ADDR_WIDTH'(nxt_idx);

    always_comb begin
        result_next = result_reg;
        result_next[{cap_idx, 3'b000} +: 8] = mem_din;
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_reg   <= IDLE;
            owner_reg   <= OWN_IC;
            addr_reg    <= '0;
            len_reg     <= '0;
            cnt_reg     <= '0;
            wdata_reg   <= '0;
            result_reg  <= '0;
            IC_data_en  <= 1'b0;
            IC_data     <= '0;
            LSB_done_en <= 1'b0;
            LSB_dout    <= '0;
            mem_dout    <= '0;
            mem_a       <= '0;
            mem_wr      <= 1'b0;
        end else if (rdy_in) begin
            IC_data_en  <= 1'b0;
            LSB_done_en <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (can_accept && (lsb_ok || IC_query_en)) begin
                        result_reg <= '0;
                        cnt_reg    <= '0;
                        if (lsb_ok) begin
                            owner_reg <= OWN_LSB;
                            addr_reg  <= LSB_query_addr;
                            mem_a     <= LSB_query_addr;
                            len_reg   <= mc_size_bytes(LSB_query_size);
                            wdata_reg <= LSB_query_data;
                            if (LSB_query_wr) begin
                                state_reg <= WRITE;
                                mem_wr    <= 1'b1;
                                mem_dout  <= LSB_query_data[7:0];
                            end else begin
                                state_reg <= READ;
                            end
                        end else begin
                            owner_reg <= OWN_IC;
                            addr_reg  <= IC_query_addr;
                            mem_a     <= IC_query_addr;
                            len_reg   <= 3'd4;
                            state_reg <= READ;
                        end
                    end
                end
                READ: begin
                    cnt_reg <= cnt_reg + 3'd1;
                    if (cnt_reg != 3'd0)
                        result_reg <= result_next;
                    if (cnt_reg == len_reg) begin
                        state_reg <= IDLE;
                        mem_a     <= '0;
                        if (owner_reg == OWN_IC) begin
                            IC_data_en <= 1'b1;
                            IC_data    <= result_next;
                        end else begin
                            LSB_done_en <= 1'b1;
                            LSB_dout    <= result_next;
                        end
                    end else if ((cnt_reg + 3'd1) < len_reg) begin
                        mem_a <= addr_next;
                    end
                end
                WRITE: begin
                    if ((cnt_reg + 3'd1) == len_reg) begin
                        state_reg   <= IDLE;
                        mem_wr      <= 1'b0;
                        mem_a       <= '0;
                        mem_dout    <= '0;
                        LSB_done_en <= 1'b1;
                        LSB_dout    <= '0;
                    end else begin
                        cnt_reg  <= cnt_reg + 3'd1;
                        mem_a    <= addr_next;
                        mem_dout <= wdata_reg[{nxt_idx, 3'b000} +: 8];
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_memory_controller.sv
// Self-checking bench for memory_controller: byte-addressed RAM model plus randomized
// fetch/load/store traffic; MC_IO_STALL_EN selects which IO-stall behaviour is expected.
module tb_memory_controller;

    logic        clk_in = 1'b0;
    logic        rst_in = 1'b1;
    logic        rdy_in = 1'b1;
    logic        IC_query_en = 1'b0;
    logic [31:0] IC_query_addr = '0;
    logic        IC_data_en;
    logic [31:0] IC_data;
    logic        LSB_query_en = 1'b0;
    logic        LSB_query_wr = 1'b0;
    logic [31:0] LSB_query_addr = '0;
    logic [1:0]  LSB_query_size = '0;
    logic [31:0] LSB_query_data = '0;
    logic        LSB_done_en;
    logic [31:0] LSB_dout;
    logic [7:0]  mem_din = '0;
    logic [7:0]  mem_dout;
    logic [31:0] mem_a;
    logic        mem_wr;
    logic        io_buffer_full = 1'b0;

    int errors = 0;
    int checks = 0;

    memory_controller dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
        .IC_query_en(IC_query_en), .IC_query_addr(IC_query_addr),
        .IC_data_en(IC_data_en), .IC_data(IC_data),
        .LSB_query_en(LSB_query_en), .LSB_query_wr(LSB_query_wr),
        .LSB_query_addr(LSB_query_addr), .LSB_query_size(LSB_query_size),
        .LSB_query_data(LSB_query_data), .LSB_done_en(LSB_done_en), .LSB_dout(LSB_dout),
        .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
        .io_buffer_full(io_buffer_full)
    );

    always #5 clk_in = ~clk_in;

    // Byte-addressed RAM; untouched locations return an address-derived pattern.
    logic [7:0] ram [logic [31:0]];

    function automatic logic [7:0] ram_rd(input logic [31:0] a);
        if (ram.exists(a)) return ram[a];
        return a[7:0] ^ {a[11:8], a[15:12]} ^ 8'h3C;
    endfunction

    always @(posedge clk_in) begin
        if (mem_wr) ram[mem_a] = mem_dout;
        mem_din <= ram_rd(mem_a);
    end

    function automatic int nbytes(input logic [1:0] sz);
        return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    endfunction

    function automatic logic [31:0] exp_load(input logic [31:0] a, input int n);
        logic [31:0] r = '0;
        for (int k = 0; k < n; k++) r[8*k +: 8] = ram_rd(a + 32'(k));
        return r;
    endfunction

    // Per-cycle bus trace of the last transaction: index j is sampled after accept edge + j.
    logic [31:0] tr_a[$];
    logic        tr_wr[$];
    logic [7:0]  tr_do[$];
    logic        pulse_after;
    logic [31:0] mem_a_after;

    task automatic run_txn(input bit is_ic, input bit wr, input logic [31:0] a,
                           input logic [1:0] sz, input logic [31:0] d,
                           output int lat, output logic [31:0] res);
        tr_a.delete(); tr_wr.delete(); tr_do.delete();
        if (is_ic) begin
            IC_query_en = 1'b1; IC_query_addr = a;
        end else begin
            LSB_query_en = 1'b1; LSB_query_wr = wr; LSB_query_addr = a;
            LSB_query_size = sz; LSB_query_data = d;
        end
        lat = -1;
        res = 'x;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk_in); @(negedge clk_in);
            tr_a.push_back(mem_a); tr_wr.push_back(mem_wr); tr_do.push_back(mem_dout);
            if (is_ic ? IC_data_en : LSB_done_en) begin
                lat = k - 1;
                res = is_ic ? IC_data : LSB_dout;
                break;
            end
        end
        IC_query_en = 1'b0; LSB_query_en = 1'b0;
        @(posedge clk_in); @(negedge clk_in);
        pulse_after = is_ic ? IC_data_en : LSB_done_en;
        mem_a_after = mem_a;
        $display("txn ic=%0d wr=%0d size=%0d addr=%h data=%h lat=%0d res=%h",
                 is_ic, wr, sz, a, d, lat, res);
    endtask

    task automatic test_reset;
        IC_query_en = 1'b1; IC_query_addr = 32'h40;
        repeat (3) @(posedge clk_in);
        @(negedge clk_in);
        checks++; if (mem_a !== 32'h0 || mem_wr !== 1'b0 || mem_dout !== 8'h0) begin
            errors++; $display("FAIL reset_bus: mem_a=%h mem_wr=%b mem_dout=%h required 0", mem_a, mem_wr, mem_dout);
        end
        checks++; if (IC_data_en !== 1'b0 || IC_data !== 32'h0) begin
            errors++; $display("FAIL reset_ic: en=%b data=%h required 0", IC_data_en, IC_data);
        end
        checks++; if (LSB_done_en !== 1'b0 || LSB_dout !== 32'h0) begin
            errors++; $display("FAIL reset_lsb: en=%b dout=%h required 0", LSB_done_en, LSB_dout);
        end
        IC_query_en = 1'b0;
        rst_in = 1'b0;
        @(posedge clk_in); @(negedge clk_in);
        $display("txn reset released");
    endtask

    task automatic test_icache_fetch;
        int lat; logic [31:0] res;
        ram[32'h100] = 8'h13; ram[32'h101] = 8'h05; ram[32'h102] = 8'h00; ram[32'h103] = 8'h00;
        run_txn(1'b1, 1'b0, 32'h100, 2'd2, 32'h0, lat, res);
        checks++; if (lat !== 5) begin errors++; $display("FAIL fetch_latency: got %0d required 5", lat); end
        checks++; if (res !== 32'h0000_0513) begin errors++; $display("FAIL fetch_data: got %h required 00000513", res); end
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (k >= tr_a.size() || tr_a[k] !== 32'h100 + 32'(k) || tr_wr[k] !== 1'b0) begin
                errors++;
                $display("FAIL fetch_addr%0d: got %h required %h", k,
                         (k < tr_a.size()) ? tr_a[k] : 32'hx, 32'h100 + 32'(k));
            end
        end
        checks++; if (pulse_after !== 1'b0) begin errors++; $display("FAIL fetch_pulse_width: IC_data_en=%b required 0", pulse_after); end
        checks++; if (mem_a_after !== 32'h0) begin errors++; $display("FAIL fetch_idle_addr: got %h required 0", mem_a_after); end
    endtask

    task automatic test_half_load;
        int lat; logic [31:0] res;
        ram[32'h1002] = 8'hFE; ram[32'h1003] = 8'hFF;
        run_txn(1'b0, 1'b0, 32'h1002, 2'd1, 32'h0, lat, res);
        checks++; if (lat !== 3) begin errors++; $display("FAIL half_latency: got %0d required 3", lat); end
        checks++; if (res !== 32'h0000_FFFE) begin errors++; $display("FAIL half_data: got %h required 0000fffe", res); end
    endtask

    task automatic test_word_store;
        int lat; logic [31:0] res;
        logic [31:0] d = 32'hDEAD_BEEF;
        run_txn(1'b0, 1'b1, 32'h2000, 2'd2, d, lat, res);
        checks++; if (lat !== 4) begin errors++; $display("FAIL store_latency: got %0d required 4", lat); end
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (k >= tr_a.size() || tr_wr[k] !== 1'b1 || tr_a[k] !== 32'h2000 + 32'(k) || tr_do[k] !== d[8*k +: 8]) begin
                errors++;
                $display("FAIL store_byte%0d: got wr=%b a=%h d=%h required wr=1 a=%h d=%h", k,
                         (k < tr_a.size()) ? tr_wr[k] : 1'bx, (k < tr_a.size()) ? tr_a[k] : 32'hx,
                         (k < tr_a.size()) ? tr_do[k] : 8'hx, 32'h2000 + 32'(k), d[8*k +: 8]);
            end
        end
        checks++; if (tr_wr.size() < 5 || tr_wr[4] !== 1'b0) begin
            errors++; $display("FAIL store_wr_drop: mem_wr at done cycle not 0 (trace len %0d)", tr_wr.size());
        end
        checks++; if (exp_load(32'h2000, 4) !== d) begin
            errors++; $display("FAIL store_ram: got %h required %h", exp_load(32'h2000, 4), d);
        end
        checks++; if (res !== 32'h0) begin errors++; $display("FAIL store_dout: got %h required 0", res); end
    endtask

    task automatic test_random;
        int lat, n, explat; logic [31:0] res, a, d, exp_r; bit is_ic, wr; logic [1:0] sz;
        for (int i = 0; i < 24; i++) begin
            is_ic = ($urandom_range(0, 2) == 0);
            wr    = !is_ic && ($urandom_range(0, 1) == 1);
            sz    = 2'($urandom_range(0, 3));
            a     = $urandom;
            if (i % 5 == 0) a = 32'hFFFF_FFFF - 32'($urandom_range(0, 2));
            d     = $urandom;
            n      = is_ic ? 4 : nbytes(sz);
            exp_r  = wr ? 32'h0 : exp_load(a, n);
            explat = wr ? n : n + 1;
            run_txn(is_ic, wr, a, sz, d, lat, res);
            checks++; if (lat !== explat) begin errors++; $display("FAIL rand%0d_latency: got %0d required %0d", i, lat, explat); end
            checks++; if (res !== exp_r) begin errors++; $display("FAIL rand%0d_data: got %h required %h", i, res, exp_r); end
            if (wr) begin
                checks++;
                if (exp_load(a, n) !== (d & ((n == 4) ? 32'hFFFF_FFFF : ((32'h1 << (8*n)) - 32'h1)))) begin
                    errors++;
                    $display("FAIL rand%0d_ram: got %h required low %0d bytes of %h", i, exp_load(a, n), n, d);
                end
            end
        end
    endtask

    task automatic test_arbitration;
        int dl = -1, di = -1, icn = 0, lsbn = 0;
        logic [31:0] lv = '0, iv = '0, exp_l, exp_i;
        exp_l = exp_load(32'h500, 4);
        exp_i = exp_load(32'h600, 4);
        LSB_query_en = 1'b1; LSB_query_wr = 1'b0; LSB_query_addr = 32'h500; LSB_query_size = 2'd2;
        IC_query_en  = 1'b1; IC_query_addr = 32'h600;
        for (int k = 1; k <= 30; k++) begin
            @(posedge clk_in); @(negedge clk_in);
            if (LSB_done_en) begin
                lsbn++;
                if (dl < 0) begin dl = k; lv = LSB_dout; end
                LSB_query_en = 1'b0;
            end
            if (IC_data_en) begin
                icn++;
                if (di < 0) begin di = k; iv = IC_data; end
                IC_query_en = 1'b0;
            end
        end
        LSB_query_en = 1'b0; IC_query_en = 1'b0;
        $display("txn arbitration lsb_done=%0d ic_done=%0d ic_pulses=%0d", dl, di, icn);
        checks++; if (dl !== 6) begin errors++; $display("FAIL arb_lsb_first: LSB done at edge %0d required 6", dl); end
        checks++; if (di !== 13) begin errors++; $display("FAIL arb_ic_after: IC done at edge %0d required 13", di); end
        checks++; if (icn !== 1 || lsbn !== 1) begin errors++; $display("FAIL arb_pulse_count: ic=%0d lsb=%0d required 1 and 1", icn, lsbn); end
        checks++; if (lv !== exp_l) begin errors++; $display("FAIL arb_lsb_data: got %h required %h", lv, exp_l); end
        checks++; if (iv !== exp_i) begin errors++; $display("FAIL arb_ic_data: got %h required %h", iv, exp_i); end
    endtask

    task automatic test_rdy_stall;
        int lat = -1; logic [31:0] res = '0, exp_r;
        exp_r = exp_load(32'h400, 4);
        LSB_query_en = 1'b1; LSB_query_wr = 1'b0; LSB_query_addr = 32'h400; LSB_query_size = 2'd2;
        for (int k = 1; k <= 30; k++) begin
            @(posedge clk_in); @(negedge clk_in);
            if (k == 1) rdy_in = 1'b0;
            if (k >= 2 && k <= 4) begin
                checks++; if (mem_a !== 32'h400) begin errors++; $display("FAIL stall_hold_addr: got %h required 00000400", mem_a); end
            end
            if (k == 4) rdy_in = 1'b1;
            if (LSB_done_en) begin lat = k - 1; res = LSB_dout; break; end
        end
        checks++; if (lat !== 8) begin errors++; $display("FAIL stall_latency: got %0d required 8", lat); end
        checks++; if (res !== exp_r) begin errors++; $display("FAIL stall_data: got %h required %h", res, exp_r); end
        rdy_in = 1'b0; LSB_query_en = 1'b0;
        repeat (2) @(posedge clk_in);
        @(negedge clk_in);
        checks++; if (LSB_done_en !== 1'b1) begin errors++; $display("FAIL stall_done_held: LSB_done_en=%b required 1", LSB_done_en); end
        rdy_in = 1'b1;
        @(posedge clk_in); @(negedge clk_in);
        checks++; if (LSB_done_en !== 1'b0) begin errors++; $display("FAIL stall_done_drop: LSB_done_en=%b required 0", LSB_done_en); end
        $display("txn rdy stall lat=%0d res=%h", lat, res);
    endtask

    task automatic test_reset_mid;
        int dones = 0, lat; logic [31:0] res, exp_r;
        LSB_query_en = 1'b1; LSB_query_wr = 1'b1; LSB_query_addr = 32'h3000;
        LSB_query_size = 2'd2; LSB_query_data = 32'h1122_3344;
        @(posedge clk_in); @(negedge clk_in);
        @(posedge clk_in); @(negedge clk_in);
        checks++; if (mem_wr !== 1'b1 || mem_dout !== 8'h33) begin errors++; $display("FAIL rstmid_second_byte: wr=%b d=%h required 1 33", mem_wr, mem_dout); end
        rst_in = 1'b1; LSB_query_en = 1'b0;
        @(posedge clk_in); @(negedge clk_in);
        rst_in = 1'b0;
        checks++; if (mem_wr !== 1'b0 || mem_a !== 32'h0) begin errors++; $display("FAIL rstmid_bus: wr=%b a=%h required 0 0", mem_wr, mem_a); end
        for (int k = 0; k < 8; k++) begin
            @(posedge clk_in); @(negedge clk_in);
            if (LSB_done_en || mem_wr) dones++;
        end
        checks++; if (dones !== 0) begin errors++; $display("FAIL rstmid_no_done: %0d cycles with done or write, required 0", dones); end
        exp_r = exp_load(32'h3100, 1);
        run_txn(1'b0, 1'b0, 32'h3100, 2'd0, 32'h0, lat, res);
        checks++; if (lat !== 2 || res !== exp_r) begin errors++; $display("FAIL rstmid_idle: lat=%0d res=%h required 2 %h", lat, res, exp_r); end
    endtask

    task automatic test_io_stall;
        int lat; logic [31:0] res;
`ifdef MC_IO_STALL_EN
        int wrs = 0; bit done_seen = 0;
        io_buffer_full = 1'b1;
        LSB_query_en = 1'b1; LSB_query_wr = 1'b1; LSB_query_addr = 32'h0003_0000;
        LSB_query_size = 2'd0; LSB_query_data = 32'h41;
        repeat (10) begin
            @(posedge clk_in); @(negedge clk_in);
            if (mem_wr || LSB_done_en) wrs++;
        end
        checks++; if (wrs !== 0) begin errors++; $display("FAIL io_stall_hold: %0d active cycles while full, required 0", wrs); end
        io_buffer_full = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk_in); @(negedge clk_in);
            if (mem_wr) wrs++;
            if (LSB_done_en) begin done_seen = 1; LSB_query_en = 1'b0; end
        end
        LSB_query_en = 1'b0;
        checks++; if (wrs !== 1 || !done_seen) begin errors++; $display("FAIL io_stall_release: writes=%0d done=%0d required 1 1", wrs, done_seen); end
        checks++; if (ram_rd(32'h0003_0000) !== 8'h41) begin errors++; $display("FAIL io_stall_ram: got %h required 41", ram_rd(32'h0003_0000)); end
        $display("txn io stall writes=%0d done=%0d", wrs, done_seen);
        lat = 0; res = '0;
`else
        io_buffer_full = 1'b1;
        run_txn(1'b0, 1'b1, 32'h0003_0000, 2'd0, 32'h41, lat, res);
        io_buffer_full = 1'b0;
        checks++; if (lat !== 1) begin errors++; $display("FAIL io_ignored_latency: got %0d required 1", lat); end
        checks++; if (ram_rd(32'h0003_0000) !== 8'h41) begin errors++; $display("FAIL io_ignored_ram: got %h required 41", ram_rd(32'h0003_0000)); end
`endif
    endtask

    initial begin
        test_reset;
        test_icache_fetch;
        test_half_load;
        test_word_store;
        test_random;
        test_arbitration;
        test_rdy_stall;
        test_reset_mid;
        test_io_stall;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish within time limit");
        $fatal(1, "timeout");
    end

endmodule
